// File: rtl/regbus_bridge.sv
// regbus_bridge: byte-stream host link to a simple register bus.
//
// A host sends a command byte (bit7 = write, bits6:4 = 000, bits3:0 = addr[11:8]), an address
// byte and, for writes, four data bytes LS first. The bridge issues one regreq pulse, waits for
// regack (or gives up after TIMEOUT wait cycles) and returns a status byte, followed by four
// read-data bytes LS first for a successful read.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   rxvalid/rxready/rxdata    host -> bridge byte stream
//   txvalid/txready/txdata    bridge -> host byte stream
//   regreq/regwr/regaddr/
//   regwdata                  register request (regreq is a one-cycle pulse)
//   regack/regerr/regrdata    register completion (regerr/regrdata valid with regack)
module regbus_bridge #(
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        rxvalid,
   output logic        rxready,
   input  logic [7:0]  rxdata,
   output logic        txvalid,
   input  logic        txready,
   output logic [7:0]  txdata,
   output logic        regreq,
   output logic        regwr,
   output logic [11:0] regaddr,
   output logic [31:0] regwdata,
   input  logic        regack,
   input  logic        regerr,
   input  logic [31:0] regrdata
);

   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {StCmd, StAddr, StData, StReq, StWait, StResp} state_e;

   state_e      state_q, state_d;
   logic        rdy_q;
   logic [15:0] cnt_q, cnt_d;       // data byte index, wait cycles, or read byte index
   logic        wr_q, wr_d;
   logic [11:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        more_q, more_d;     // read data bytes still follow the status byte
   logic        txvalid_q, txvalid_d;
   logic [7:0]  txdata_q, txdata_d;
   logic        rx_fire, tx_fire;

   // rdy_q keeps rxready low until the first edge after reset release.
   assign rxready  = rdy_q & (state_q inside {StCmd, StAddr, StData});
   assign rx_fire  = rxvalid & rxready;
   assign tx_fire  = txvalid_q & txready;
   assign regreq   = (state_q == StReq);
   assign regwr    = wr_q;
   assign regaddr  = addr_q;
   assign regwdata = wdata_q;
   assign txvalid  = txvalid_q;
   assign txdata   = txdata_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      more_d    = more_q;
      txvalid_d = txvalid_q;
      txdata_d  = txdata_q;

      case (state_q)
         StCmd: begin
            if (rx_fire) begin
               if (rxdata[6:4] != 3'b000) begin
                  state_d   = StResp;
                  txvalid_d = 1'b1;
                  txdata_d  = 8'h03;
                  more_d    = 1'b0;
                  cnt_d     = '0;
               end else begin
                  wr_d         = rxdata[7];
                  addr_d[11:8] = rxdata[3:0];
                  state_d      = StAddr;
               end
            end
         end
         StAddr: begin
            if (rx_fire) begin
               addr_d[7:0] = rxdata;
               cnt_d       = '0;
               state_d     = wr_q ? StData : StReq;
            end
         end
         StData: begin
            if (rx_fire) begin
               // Shift in from the top so the first byte ends up least significant.
               wdata_d = {rxdata, wdata_q[31:8]};
               if (cnt_q == 16'd3) begin
                  cnt_d   = '0;
                  state_d = StReq;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         StReq, StWait: begin
            if (regack) begin
               state_d   = StResp;
               txvalid_d = 1'b1;
               txdata_d  = regerr ? 8'h01 : 8'h00;
               more_d    = ~wr_q & ~regerr;
               rdata_d   = regrdata;
               cnt_d     = '0;
            end else if (state_q == StReq) begin
               state_d = StWait;
               cnt_d   = '0;
            end else if (cnt_q == TimeoutLast) begin
               state_d   = StResp;
               txvalid_d = 1'b1;
               txdata_d  = 8'h02;
               more_d    = 1'b0;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StResp: begin
            if (tx_fire) begin
               if (more_q && (cnt_q < 16'd4)) begin
                  txdata_d = rdata_q[7:0];
                  rdata_d  = {8'h00, rdata_q[31:8]};
                  cnt_d    = cnt_q + 16'd1;
               end else begin
                  txvalid_d = 1'b0;
                  cnt_d     = '0;
                  state_d   = StCmd;
               end
            end
         end
         default: state_d = StCmd;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= StCmd;
         rdy_q     <= 1'b0;
         cnt_q     <= '0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         more_q    <= 1'b0;
         txvalid_q <= 1'b0;
         txdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         rdy_q     <= 1'b1;
         cnt_q     <= cnt_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         more_q    <= more_d;
         txvalid_q <= txvalid_d;
         txdata_q  <= txdata_d;
      end
   end

endmodule

// File: tb/tb_regbus_bridge.sv
// Self-checking bench for regbus_bridge: directed scenarios with literal expectations followed
// by randomized transactions whose expectations come from a transaction-level model.
module tb_regbus_bridge;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        rxvalid = 1'b0;
   logic        rxready;
   logic [7:0]  rxdata = 8'h00;
   logic        txvalid;
   logic        txready = 1'b1;
   logic [7:0]  txdata;
   logic        regreq;
   logic        regwr;
   logic [11:0] regaddr;
   logic [31:0] regwdata;
   logic        regack = 1'b0;
   logic        regerr = 1'b0;
   logic [31:0] regrdata = 32'h0;

   always #5 clk = ~clk;

   regbus_bridge #(.TIMEOUT(TO)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .rxvalid  (rxvalid),
      .rxready  (rxready),
      .rxdata   (rxdata),
      .txvalid  (txvalid),
      .txready  (txready),
      .txdata   (txdata),
      .regreq   (regreq),
      .regwr    (regwr),
      .regaddr  (regaddr),
      .regwdata (regwdata),
      .regack   (regack),
      .regerr   (regerr),
      .regrdata (regrdata)
   );

   typedef struct {
      logic        wr;
      logic [11:0] addr;
      logic [31:0] wdata;
      int          lat;   // cycles from regreq to first txvalid
   } req_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  exp_tx[$];
   req_t        exp_req[$];
   logic [7:0]  rxq[$];
   logic [7:0]  txq[$];
   bit          rx_done = 1'b0;
   int          tx_mode = 0;
   int          sl_dly = -1;
   bit          sl_err = 1'b0;
   logic [31:0] sl_rdata = 32'h0;
   bit          sl_busy = 1'b0;
   logic [31:0] model_wdata = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic evt_fail(input string name, input string what);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %s, want none at %0t", name, what, $time);
   endtask

   // txready pattern: 0 always ready, 1 toggling, 2 random.
   initial forever begin
      @(posedge clk);
      #1;
      case (tx_mode)
         0:       txready = 1'b1;
         1:       txready = ~txready;
         default: txready = 1'($urandom_range(0, 1));
      endcase
   end

   // Register slave: acks sl_dly cycles after the regreq cycle (0 = same cycle, <0 = never).
   initial forever begin
      @(negedge clk);
      if (rstn && regreq) begin
         sl_busy = 1'b1;
         if (sl_dly >= 0) begin
            repeat (sl_dly) @(negedge clk);
            regack   = 1'b1;
            regerr   = sl_err;
            regrdata = sl_rdata;
            @(negedge clk);
            regack   = 1'b0;
            regerr   = 1'b0;
            regrdata = $urandom;
         end
         sl_busy = 1'b0;
      end
   end

   // Compare process: checks every cycle against the expected request / response queues.
   int          cyc = 0;
   int          req_cyc = 0;
   int          lat_exp = 0;
   bit          lat_pend = 1'b0;
   bit          hold_on = 1'b0;
   bit          prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'h00;
   req_t        hold;

   initial forever begin
      @(negedge clk);
      cyc++;
      if (rstn) begin
         if (rx_done) chk("rxready_busy", 32'(rxready), 32'd0);
         if (hold_on) begin
            chk("regwr_hold", 32'(regwr), 32'(hold.wr));
            chk("regaddr_hold", 32'(regaddr), 32'(hold.addr));
            chk("regwdata_hold", regwdata, hold.wdata);
         end
         if (prev_stall) begin
            chk("txvalid_stall", 32'(txvalid), 32'd1);
            chk("txdata_stall", 32'(txdata), 32'(prev_data));
         end
         if (regreq) begin
            if (exp_req.size() == 0) begin
               evt_fail("regreq", "unexpected regreq");
            end else begin
               hold = exp_req.pop_front();
               chk("regwr", 32'(regwr), 32'(hold.wr));
               chk("regaddr", 32'(regaddr), 32'(hold.addr));
               chk("regwdata", regwdata, hold.wdata);
               hold_on  = 1'b1;
               req_cyc  = cyc;
               lat_exp  = hold.lat;
               lat_pend = 1'b1;
            end
         end
         if (txvalid && lat_pend) begin
            chk("resp_latency", 32'(cyc - req_cyc), 32'(lat_exp));
            lat_pend = 1'b0;
         end
         if (txvalid && txready) begin
            if (exp_tx.size() == 0) begin
               evt_fail("tx", $sformatf("unexpected byte 0x%0h", txdata));
            end else begin
               chk("txdata", 32'(txdata), 32'(exp_tx.pop_front()));
               if (exp_tx.size() == 0) begin
                  rx_done = 1'b0;
                  hold_on = 1'b0;
               end
            end
         end
         prev_stall = txvalid && !txready;
         prev_data  = txdata;
      end else begin
         prev_stall = 1'b0;
         lat_pend   = 1'b0;
         hold_on    = 1'b0;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      rxvalid = 1'b1;
      rxdata  = b;
      while (!rxready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!rxready) evt_fail("rx_accept", "bound expired");
      @(negedge clk);
      rxvalid = 1'b0;
      rxdata  = 8'($urandom);
   endtask

   // Sends rxq, expects txq back and (if has_req) exactly one matching request.
   task automatic do_txn(input bit has_req, input logic wr, input logic [11:0] addr,
                         input logic [31:0] wdata, input int lat, input int dly, input bit err,
                         input logic [31:0] rd);
      req_t r;
      int   n;
      sl_dly   = dly;
      sl_err   = err;
      sl_rdata = rd;
      foreach (txq[i]) exp_tx.push_back(txq[i]);
      if (has_req) begin
         r.wr    = wr;
         r.addr  = addr;
         r.wdata = wdata;
         r.lat   = lat;
         exp_req.push_back(r);
      end
      foreach (rxq[i]) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send_byte(rxq[i]);
      end
      rx_done = (exp_tx.size() != 0);
      n = 0;
      while (exp_tx.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (exp_tx.size() != 0) begin
         evt_fail("tx_drain", "bound expired");
         exp_tx.delete();
         rx_done = 1'b0;
      end
      n = 0;
      while (sl_busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("req_left", 32'(exp_req.size()), 32'd0);
      exp_req.delete();
      @(negedge clk);
   endtask

   // Transaction-level model: expected bytes and request follow from the command rules alone.
   task automatic model_txn(input bit bad, input logic wr, input logic [11:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd, input bit err,
                            input int dly);
      bit acked;
      rxq.delete();
      txq.delete();
      if (bad) begin
         rxq.push_back({wr, 3'($urandom_range(1, 7)), addr[11:8]});
         txq.push_back(8'h03);
         do_txn(1'b0, 1'b0, 12'h0, 32'h0, 0, -1, 1'b0, 32'h0);
      end else begin
         acked = (dly >= 0) && (dly <= TO);
         rxq.push_back({wr, 3'b000, addr[11:8]});
         rxq.push_back(addr[7:0]);
         if (wr) begin
            for (int k = 0; k < 4; k++) rxq.push_back(wd[8*k +: 8]);
            model_wdata = wd;
         end
         if (!acked)   txq.push_back(8'h02);
         else if (err) txq.push_back(8'h01);
         else if (wr)  txq.push_back(8'h00);
         else begin
            txq.push_back(8'h00);
            for (int k = 0; k < 4; k++) txq.push_back(rd[8*k +: 8]);
         end
         do_txn(1'b1, wr, addr, model_wdata, acked ? dly + 1 : TO + 1, dly, err, rd);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rxready"}, 32'(rxready), 32'd0);
      chk({tag, "_txvalid"}, 32'(txvalid), 32'd0);
      chk({tag, "_txdata"}, 32'(txdata), 32'd0);
      chk({tag, "_regreq"}, 32'(regreq), 32'd0);
      chk({tag, "_regwr"}, 32'(regwr), 32'd0);
      chk({tag, "_regaddr"}, 32'(regaddr), 32'd0);
      chk({tag, "_regwdata"}, regwdata, 32'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk_reset_outputs("rst");
      rstn = 1'b1;
      @(negedge clk);
      chk("rxready_release", 32'(rxready), 32'd1);

      // Read 0x00C, ack 3 cycles after regreq.
      rxq = '{8'h00, 8'h0C};
      txq = '{8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
      do_txn(1'b1, 1'b0, 12'h00C, 32'h0, 4, 3, 1'b0, 32'h12345678);
      // Write 0x000.
      rxq = '{8'h80, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      txq = '{8'h00};
      do_txn(1'b1, 1'b1, 12'h000, 32'h04030201, 3, 2, 1'b0, 32'h0);
      // Slave error on read of 0x010; regwdata keeps the last write.
      rxq = '{8'h00, 8'h10};
      txq = '{8'h01};
      do_txn(1'b1, 1'b0, 12'h010, 32'h04030201, 2, 1, 1'b1, 32'hDEADBEEF);
      // Timeout with no ack.
      rxq = '{8'h00, 8'h20};
      txq = '{8'h02};
      do_txn(1'b1, 1'b0, 12'h020, 32'h04030201, 9, -1, 1'b0, 32'h0);
      // Late ack after timeout must be ignored.
      rxq = '{8'h00, 8'h24};
      txq = '{8'h02};
      do_txn(1'b1, 1'b0, 12'h024, 32'h04030201, 9, 10, 1'b0, 32'h11111111);
      // Ack in the timeout cycle wins.
      rxq = '{8'h00, 8'h28};
      txq = '{8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
      do_txn(1'b1, 1'b0, 12'h028, 32'h04030201, 9, 8, 1'b0, 32'hCAFEF00D);
      // Ack in the regreq cycle itself; high address nibble from the command byte.
      rxq = '{8'h0A, 8'h55};
      txq = '{8'h00, 8'h5A, 8'h5A, 8'hA5, 8'hA5};
      do_txn(1'b1, 1'b0, 12'hA55, 32'h04030201, 1, 0, 1'b0, 32'hA5A55A5A);
      // Bad command.
      rxq = '{8'h70};
      txq = '{8'h03};
      do_txn(1'b0, 1'b0, 12'h0, 32'h0, 0, -1, 1'b0, 32'h0);
      // Read with txready toggling every cycle.
      tx_mode = 1;
      rxq = '{8'h00, 8'h0C};
      txq = '{8'h00, 8'hEF, 8'hCD, 8'hAB, 8'h89};
      do_txn(1'b1, 1'b0, 12'h00C, 32'h04030201, 3, 2, 1'b0, 32'h89ABCDEF);
      tx_mode = 0;

      // Reset during DATA after two data bytes.
      @(negedge clk);
      send_byte(8'h80);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h02);
      rstn = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      model_wdata = 32'h0;
      @(negedge clk);
      chk("rxready_rerelease", 32'(rxready), 32'd1);
      repeat (20) @(negedge clk);
      rxq = '{8'h00, 8'h04};
      txq = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
      do_txn(1'b1, 1'b0, 12'h004, 32'h0, 2, 1, 1'b0, 32'h00000001);
      rxq = '{8'h80, 8'h30, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      txq = '{8'h00};
      do_txn(1'b1, 1'b1, 12'h030, 32'hDDCCBBAA, 3, 2, 1'b0, 32'h0);
      model_wdata = 32'hDDCCBBAA;

      // Randomized traffic with random backpressure.
      tx_mode = 2;
      for (int t = 0; t < 60; t++) begin
         int sel;
         int dly;
         sel = int'($urandom_range(0, 9));
         if (sel <= 6)      dly = int'($urandom_range(0, TO));
         else if (sel == 7) dly = TO;
         else if (sel == 8) dly = -1;
         else               dly = TO + int'($urandom_range(1, 3));
         model_txn(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 12'($urandom),
                   $urandom, $urandom, ($urandom_range(0, 3) == 0), dly);
      end
      tx_mode = 0;
      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of run, want $finish before 2 ms");
      $fatal(1, "watchdog expired");
   end

endmodule
